// File: rtl/player_move_if.sv
// Key, tile-memory and position signals of the player movement controller.
// The master modport is the controller; slave is the surrounding system.
interface player_move_if;
  logic        key_up;
  logic        key_down;
  logic        key_left;
  logic        key_right;
  logic        query_valid;
  logic [3:0]  query_x;
  logic [3:0]  query_y;
  logic        tile_valid;
  logic [15:0] tile_id;
  logic [3:0]  player_x;
  logic [3:0]  player_y;
  logic        move_done;
  logic        move_blocked;
  logic        busy;

  modport master (
    input  key_up, key_down, key_left, key_right, tile_valid, tile_id,
    output query_valid, query_x, query_y, player_x, player_y,
           move_done, move_blocked, busy
  );

  modport slave (
    output key_up, key_down, key_left, key_right, tile_valid, tile_id,
    input  query_valid, query_x, query_y, player_x, player_y,
           move_done, move_blocked, busy
  );
endinterface

// File: rtl/player_move_ctrl.sv
// Player movement controller: turns key requests into tile-map reads,
// classifies the returned tile and commits or rejects the grid move.
//
// state   | meaning
// IDLE    | waiting for a key with the repeat counter expired
// WAIT    | read issued, waiting for tile_valid or timeout
// RESOLVE | wall test on the captured tile, commit or reject
// HOLD    | hold-to-repeat delay, left early when all keys release
module player_move_ctrl #(
  parameter int          GRID_W     = 16,
  parameter int          GRID_H     = 16,
  parameter int          INIT_X     = 1,
  parameter int          INIT_Y     = 1,
  parameter logic [15:0] WALL_LO    = 16'h0000,
  parameter logic [15:0] WALL_HI    = 16'h0002,
  parameter int          RD_TIMEOUT = 8,
  parameter logic [23:0] REPEAT_CYC = 24'd5_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  player_move_if.master pm
);

  localparam int WAIT_W = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESOLVE, HOLD} state_t;

  state_t              state_q, state_d;
  logic [3:0]          player_x_q, player_x_d, player_y_q, player_y_d;
  logic [3:0]          query_x_q, query_x_d, query_y_q, query_y_d;
  logic                query_valid_q, query_valid_d;
  logic                done_q, done_d, blocked_q, blocked_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [23:0]         rep_cnt_q, rep_cnt_d;
  logic [15:0]         tile_q, tile_d;

  logic                any_key, in_bounds, is_wall;
  logic signed [4:0]   tgt_x, tgt_y;
  logic [15:0]         tile_off;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      player_x_q    <= 4'(INIT_X);
      player_y_q    <= 4'(INIT_Y);
      query_x_q     <= '0;
      query_y_q     <= '0;
      query_valid_q <= 1'b0;
      done_q        <= 1'b0;
      blocked_q     <= 1'b0;
      wait_cnt_q    <= '0;
      rep_cnt_q     <= '0;
      tile_q        <= '0;
    end else begin
      state_q       <= state_d;
      player_x_q    <= player_x_d;
      player_y_q    <= player_y_d;
      query_x_q     <= query_x_d;
      query_y_q     <= query_y_d;
      query_valid_q <= query_valid_d;
      done_q        <= done_d;
      blocked_q     <= blocked_d;
      wait_cnt_q    <= wait_cnt_d;
      rep_cnt_q     <= rep_cnt_d;
      tile_q        <= tile_d;
    end
  end

  // Target cell in 5-bit signed space so a step off the top/left edge is negative.
  always_comb begin
    any_key = pm.key_up | pm.key_down | pm.key_left | pm.key_right;
    tgt_x   = $signed({1'b0, player_x_q});
    tgt_y   = $signed({1'b0, player_y_q});
    if (pm.key_up)         tgt_y = tgt_y - 5'sd1;
    else if (pm.key_down)  tgt_y = tgt_y + 5'sd1;
    else if (pm.key_left)  tgt_x = tgt_x - 5'sd1;
    else if (pm.key_right) tgt_x = tgt_x + 5'sd1;
    in_bounds = (tgt_x >= 5'sd0) && (int'(tgt_x) <= GRID_W - 1) &&
                (tgt_y >= 5'sd0) && (int'(tgt_y) <= GRID_H - 1);
    // Modular offset turns the inclusive range test into a single compare.
    tile_off = tile_q - WALL_LO;
    is_wall  = tile_off <= (WALL_HI - WALL_LO);
  end

  always_comb begin
    state_d       = state_q;
    player_x_d    = player_x_q;
    player_y_d    = player_y_q;
    query_x_d     = query_x_q;
    query_y_d     = query_y_q;
    query_valid_d = 1'b0;
    done_d        = 1'b0;
    blocked_d     = 1'b0;
    wait_cnt_d    = wait_cnt_q;
    rep_cnt_d     = rep_cnt_q;
    tile_d        = tile_q;
    case (state_q)
      IDLE: begin
        if (any_key && rep_cnt_q == 24'd0) begin
          if (!in_bounds) begin
            blocked_d = 1'b1;
            rep_cnt_d = REPEAT_CYC - 24'd1;
            state_d   = HOLD;
          end else begin
            query_x_d     = tgt_x[3:0];
            query_y_d     = tgt_y[3:0];
            query_valid_d = 1'b1;
            wait_cnt_d    = '0;
            state_d       = WAIT;
          end
        end
      end
      WAIT: begin
        if (pm.tile_valid && !query_valid_q) begin
          tile_d  = pm.tile_id;
          state_d = RESOLVE;
        end else if (wait_cnt_q == WAIT_W'(RD_TIMEOUT - 1)) begin
          blocked_d = 1'b1;
          rep_cnt_d = REPEAT_CYC - 24'd1;
          state_d   = HOLD;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      RESOLVE: begin
        if (is_wall) begin
          blocked_d = 1'b1;
        end else begin
          player_x_d = query_x_q;
          player_y_d = query_y_q;
          done_d     = 1'b1;
        end
        rep_cnt_d = REPEAT_CYC - 24'd1;
        state_d   = HOLD;
      end
      HOLD: begin
        if (!any_key || rep_cnt_q <= 24'd1) begin
          rep_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          rep_cnt_d = rep_cnt_q - 24'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pm.query_valid  = query_valid_q;
    pm.query_x      = query_x_q;
    pm.query_y      = query_y_q;
    pm.player_x     = player_x_q;
    pm.player_y     = player_y_q;
    pm.move_done    = done_q;
    pm.move_blocked = blocked_q;
    pm.busy         = (state_q != IDLE);
  end

endmodule

// File: tb/tb_player_move_ctrl.sv
// Scoreboard bench for player_move_ctrl: directed key sequences push expected
// query/done/blocked events; a negedge monitor pops and compares them.
module tb_player_move_ctrl;

  localparam int K_Q = 0, K_D = 1, K_B = 2;
  localparam logic [3:0] UP = 4'b1000, DOWN = 4'b0100, LEFT = 4'b0010, RIGHT = 4'b0001;

  typedef struct {
    int kind;
    int x;
    int y;
    int at;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  player_move_if pm();

  player_move_ctrl #(
    .GRID_W(16), .GRID_H(16), .INIT_X(1), .INIT_Y(1),
    .WALL_LO(16'h0000), .WALL_HI(16'h0002),
    .RD_TIMEOUT(8), .REPEAT_CYC(24'd4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .pm   (pm)
  );

  int          cyc = 0;
  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        mem_en = 1'b1;
  logic [15:0] mem_tile = 16'h0005;
  logic        stray = 1'b0;
  logic        pend = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Tile memory with one cycle of latency, plus an injectable stray strobe.
  initial begin
    pm.tile_valid = 1'b0;
    pm.tile_id    = 16'h0000;
    forever begin
      @(posedge clk);
      #2;
      pm.tile_valid = (pend & mem_en) | stray;
      pm.tile_id    = stray ? 16'h0005 : mem_tile;
      pend          = pm.query_valid;
    end
  end

  function automatic void push(input int kind, input int x, input int y, input int at);
    exp_t e;
    e.kind = kind; e.x = x; e.y = y; e.at = at;
    sbq.push_back(e);
  endfunction

  function automatic void sb_check(input int kind, input int x, input int y);
    exp_t e;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_bad++;
      $display("FAIL sb_unexpected kind=%0d got (%0d,%0d) at cyc %0d, required no event",
               kind, x, y, cyc);
    end else begin
      e = sbq.pop_front();
      if (e.kind != kind || e.x != x || e.y != y || e.at != cyc) begin
        n_bad++;
        $display("FAIL sb_event got kind=%0d (%0d,%0d) cyc %0d, required kind=%0d (%0d,%0d) cyc %0d",
                 kind, x, y, cyc, e.kind, e.x, e.y, e.at);
      end
    end
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (pm.query_valid) sb_check(K_Q, int'(pm.query_x), int'(pm.query_y));
      if (pm.move_done) sb_check(K_D, int'(pm.player_x), int'(pm.player_y));
      if (pm.move_blocked) sb_check(K_B, int'(pm.player_x), int'(pm.player_y));
      if (pm.move_done && pm.move_blocked) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pulse_exclusive got done=1 blocked=1 at cyc %0d, required not both", cyc);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic set_keys(input logic [3:0] k);
    pm.key_up    = k[3];
    pm.key_down  = k[2];
    pm.key_left  = k[1];
    pm.key_right = k[0];
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(1);
    rst_n = 1'b0;
    set_keys(4'b0000);
    tick(1);
    rst_n = 1'b1;
  endtask

  // One-cycle key press that issues a read; result is done or blocked.
  task automatic move(input logic [3:0] k, input int qx, input int qy,
                      input int kind, input int px, input int py);
    int n;
    n = cyc;
    push(K_Q, qx, qy, n + 1);
    push(kind, px, py, n + 4);
    set_keys(k);
    tick(1);
    set_keys(4'b0000);
    tick(8);
  endtask

  // One-cycle key press toward an edge: no read, blocked next cycle.
  task automatic edge_hit(input logic [3:0] k, input int px, input int py);
    int n;
    n = cyc;
    push(K_B, px, py, n + 1);
    set_keys(k);
    tick(1);
    set_keys(4'b0000);
    tick(6);
  endtask

  task automatic chk_pos(input string name, input int x, input int y);
    chk({name, "_x"}, int'(pm.player_x), x);
    chk({name, "_y"}, int'(pm.player_y), y);
  endtask

  initial begin
    int n;
    set_keys(4'b0000);
    rst_n = 1'b0;
    tick(2);
    chk_pos("reset_pos", 1, 1);
    chk("reset_query_valid", int'(pm.query_valid), 0);
    chk("reset_query_x", int'(pm.query_x), 0);
    chk("reset_query_y", int'(pm.query_y), 0);
    chk("reset_done", int'(pm.move_done), 0);
    chk("reset_blocked", int'(pm.move_blocked), 0);
    chk("reset_busy", int'(pm.busy), 0);
    rst_n = 1'b1;

    // Right with passable tile; done four cycles after the key.
    n = cyc;
    push(K_Q, 2, 1, n + 1);
    push(K_D, 2, 1, n + 4);
    set_keys(RIGHT);
    tick(1);
    set_keys(4'b0000);
    chk("t1_busy_wait", int'(pm.busy), 1);
    tick(3);
    chk("t1_busy_done", int'(pm.busy), 1);
    tick(1);
    chk("t1_busy_released", int'(pm.busy), 0);
    chk_pos("t1_pos", 2, 1);
    tick(4);

    // Up into a wall tile.
    do_reset();
    mem_tile = 16'h0001;
    move(UP, 1, 0, K_B, 1, 1);
    chk_pos("t2_pos", 1, 1);

    // Wall range boundaries: WALL_HI is a wall, one above is passable.
    mem_tile = 16'h0002;
    move(RIGHT, 2, 1, K_B, 1, 1);
    mem_tile = 16'h0003;
    move(RIGHT, 2, 1, K_D, 2, 1);
    mem_tile = 16'hFFFF;
    move(LEFT, 1, 1, K_D, 1, 1);

    // Walk to the corner, then push against both edges.
    mem_tile = 16'h0005;
    move(LEFT, 0, 1, K_D, 0, 1);
    move(UP, 0, 0, K_D, 0, 0);
    edge_hit(LEFT, 0, 0);
    edge_hit(UP, 0, 0);
    chk_pos("t3_pos", 0, 0);

    // Hold down: repeats every 7 cycles until the bottom edge blocks.
    do_reset();
    n = cyc;
    for (int k = 0; k < 14; k++) begin
      push(K_Q, 1, 2 + k, n + 1 + 7 * k);
      push(K_D, 1, 2 + k, n + 4 + 7 * k);
    end
    push(K_B, 1, 15, n + 99);
    set_keys(DOWN);
    tick(99);
    set_keys(4'b0000);
    tick(6);
    chk_pos("t4_pos", 1, 15);

    // Read timeout: blocked eight cycles after WAIT entry.
    do_reset();
    mem_en = 1'b0;
    n = cyc;
    push(K_Q, 2, 1, n + 1);
    push(K_B, 1, 1, n + 9);
    set_keys(RIGHT);
    tick(1);
    set_keys(4'b0000);
    tick(13);
    chk_pos("t5_pos", 1, 1);

    // Reset in the middle of WAIT while held, then a late tile_valid.
    mem_en = 1'b1;
    n = cyc;
    push(K_Q, 2, 1, n + 1);
    set_keys(RIGHT);
    mem_en = 1'b0;
    tick(4);
    rst_n = 1'b0;
    set_keys(4'b0000);
    tick(1);
    rst_n = 1'b1;
    stray = 1'b1;
    chk("t5r_query_valid", int'(pm.query_valid), 0);
    chk("t5r_query_x", int'(pm.query_x), 0);
    chk("t5r_query_y", int'(pm.query_y), 0);
    chk("t5r_busy", int'(pm.busy), 0);
    chk("t5r_done", int'(pm.move_done), 0);
    chk("t5r_blocked", int'(pm.move_blocked), 0);
    chk_pos("t5r_pos", 1, 1);
    tick(1);
    stray = 1'b0;
    mem_en = 1'b1;
    tick(8);
    chk("t5r_idle_after_stray", int'(pm.busy), 0);

    // Walk to (5,5), then up+right together: up wins.
    do_reset();
    for (int i = 2; i <= 5; i++) move(RIGHT, i, 1, K_D, i, 1);
    for (int j = 2; j <= 5; j++) move(DOWN, 5, j, K_D, 5, j);
    move(UP | RIGHT, 5, 4, K_D, 5, 4);
    chk_pos("t6_pos", 5, 4);

    tick(4);
    chk("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
